seq_delay_match: RTL and testbench

- Hardware evaluator for the sequence `a ##[MIN:MAX] b`, with optional first_match semantics and disable-iff.
- Consumes per-cycle boolean samples and keeps every overlapping attempt in flight.
- Emits registered match/fail events and a saturating cover count.
- Sits directly downstream of the boolean sampling logic and feeds the cover/assert reporting stage.

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_popcount.sv | 24 ++
 rtl/seq_delay_match.sv | 123 ++++++++++++
 tb/tb_seq_delay_match.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// +----------------------------------------------------------------------------+
// | seq_pkg : shared constants, helpers and elaboration checks for the         |
// |           a ##[MIN:MAX] b sequence evaluator                               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package seq_pkg;

    localparam int MAX_DLY_LIMIT = 31;

    // Width needed to count up to MAX_DLY+1 simultaneous matches.
    function automatic int cnt_w(input int max_dly);
        return $clog2(max_dly + 2);
    endfunction

endpackage

`define SEQ_PARAM_CHECK(MIN_V, MAX_V) \
    if (((MIN_V) > (MAX_V)) || ((MAX_V) > seq_pkg::MAX_DLY_LIMIT) || ((MIN_V) < 0)) begin : g_param_err \
        $error("seq_delay_match: illegal delay window MIN_DLY=%0d MAX_DLY=%0d", MIN_V, MAX_V); \
    end

`default_nettype wire

// File: rtl/seq_popcount.sv
// +----------------------------------------------------------------------------+
// | seq_popcount : combinational count of set bits in a vector                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_popcount #(
    parameter int WIDTH = 3,
    parameter int OUT_W = 2
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic [OUT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + OUT_W'(i_bits[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_delay_match.sv
// +----------------------------------------------------------------------------+
// | seq_delay_match : evaluates a ##[MIN_DLY:MAX_DLY] b over overlapping        |
// |                   attempts, with first_match, disable iff and cover count  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module seq_delay_match
    import seq_pkg::*;
#(
    parameter int MIN_DLY     = 1,
    parameter int MAX_DLY     = 2,
    parameter bit FIRST_MATCH = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        a_i,
    input  logic                        b_i,
    input  logic                        disable_i,
    input  logic                        clear_cnt_i,
    output logic                        match_o,
    output logic [cnt_w(MAX_DLY)-1:0]   match_num_o,
    output logic                        fail_o,
    output logic                        active_o,
    output logic [CNT_W-1:0]            match_total_o
);

    `SEQ_PARAM_CHECK(MIN_DLY, MAX_DLY)

    localparam int c_NW = cnt_w(MAX_DLY);
    localparam int c_LW = (MAX_DLY > 0) ? MAX_DLY : 1;
    localparam int c_SW = ((CNT_W > c_NW) ? CNT_W : c_NW) + 1;
    localparam logic [c_SW-1:0] c_SAT = c_SW'({CNT_W{1'b1}});

    logic [c_LW-1:0]    r_live;
    logic [c_LW-1:0]    r_mflag;
    logic [c_LW-1:0]    w_live_nxt;
    logic [c_LW-1:0]    w_mflag_nxt;
    logic [MAX_DLY:0]   w_cur;
    logic [MAX_DLY:0]   w_curm;
    logic [MAX_DLY:0]   w_hit;
    logic               w_miss;
    logic [c_NW-1:0]    w_pop;
    logic [c_SW-1:0]    w_sum;
    logic [CNT_W-1:0]   w_total_nxt;

    logic               r_match;
    logic [c_NW-1:0]    r_num;
    logic               r_fail;
    logic               r_active;
    logic [CNT_W-1:0]   r_total;

    // Slot k of the age vector holds the attempt started k cycles ago.
    always_comb begin
        w_cur       = '0;
        w_curm      = '0;
        w_hit       = '0;
        w_live_nxt  = '0;
        w_mflag_nxt = '0;
        w_cur[0]    = a_i;
        for (int k = 1; k <= MAX_DLY; k++) begin
            w_cur[k]  = r_live[k-1];
            w_curm[k] = !FIRST_MATCH && r_mflag[k-1];
        end
        if (!disable_i) begin
            for (int k = MIN_DLY; k <= MAX_DLY; k++) begin
                w_hit[k] = w_cur[k] & b_i;
            end
            for (int k = 0; k < MAX_DLY; k++) begin
                w_live_nxt[k]  = w_cur[k] & ~(FIRST_MATCH & w_hit[k]);
                w_mflag_nxt[k] = w_curm[k] | (!FIRST_MATCH && w_hit[k]);
            end
        end
    end

    // An attempt reaching the window end without ever matching is a failure.
    assign w_miss = !disable_i && w_cur[MAX_DLY] && !b_i && !w_curm[MAX_DLY];

    seq_popcount #(
        .WIDTH (MAX_DLY + 1),
        .OUT_W (c_NW)
    ) u_popcount (
        .i_bits  (w_hit),
        .o_count (w_pop)
    );

    assign w_sum       = c_SW'(r_total) + c_SW'(w_pop);
    assign w_total_nxt = (w_sum > c_SAT) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_live   <= '0;
            r_mflag  <= '0;
            r_match  <= 1'b0;
            r_num    <= '0;
            r_fail   <= 1'b0;
            r_active <= 1'b0;
            r_total  <= '0;
        end else begin
            r_live   <= w_live_nxt;
            r_mflag  <= w_mflag_nxt;
            r_match  <= |w_hit;
            r_num    <= w_pop;
            r_fail   <= w_miss;
            r_active <= |w_live_nxt;
            if (clear_cnt_i) begin
                r_total <= '0;
            end else begin
                r_total <= w_total_nxt;
            end
        end
    end

    assign match_o       = r_match;
    assign match_num_o   = r_num;
    assign fail_o        = r_fail;
    assign active_o      = r_active;
    assign match_total_o = r_total;

endmodule

`default_nettype wire

// File: tb/tb_seq_delay_match.sv
// +----------------------------------------------------------------------------+
// | tb_seq_delay_match : directed vector bench for seq_delay_match             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seq_delay_match;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic dis;
    logic clr;

    logic        m1, f1, act1;
    logic [1:0]  n1;
    logic [15:0] t1;
    logic        m0, f0, act0;
    logic [1:0]  n0;
    logic [15:0] t0;
    logic        ms, fs, acts;
    logic [1:0]  ns;
    logic [1:0]  ts;
    logic        mz, fz, actz;
    logic [1:0]  nz;
    logic [15:0] tz;

    int checks = 0;
    int errors = 0;

    seq_delay_match #(.MIN_DLY(1), .MAX_DLY(2), .FIRST_MATCH(1'b1), .CNT_W(16)) dut_fm1 (
        .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .disable_i(dis), .clear_cnt_i(clr),
        .match_o(m1), .match_num_o(n1), .fail_o(f1), .active_o(act1), .match_total_o(t1));

    seq_delay_match #(.MIN_DLY(1), .MAX_DLY(2), .FIRST_MATCH(1'b0), .CNT_W(16)) dut_fm0 (
        .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .disable_i(dis), .clear_cnt_i(clr),
        .match_o(m0), .match_num_o(n0), .fail_o(f0), .active_o(act0), .match_total_o(t0));

    seq_delay_match #(.MIN_DLY(1), .MAX_DLY(2), .FIRST_MATCH(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .disable_i(dis), .clear_cnt_i(clr),
        .match_o(ms), .match_num_o(ns), .fail_o(fs), .active_o(acts), .match_total_o(ts));

    seq_delay_match #(.MIN_DLY(0), .MAX_DLY(2), .FIRST_MATCH(1'b1), .CNT_W(16)) dut_z (
        .clk(clk), .rst_n(rst_n), .a_i(a), .b_i(b), .disable_i(dis), .clear_cnt_i(clr),
        .match_o(mz), .match_num_o(nz), .fail_o(fz), .active_o(actz), .match_total_o(tz));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, a, b, dis, clr;
        logic        m;
        logic [1:0]  n;
        logic        f, act;
        logic [15:0] tot;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input logic r, input logic ai, input logic bi, input logic di, input logic ci);
        rst_n = r;
        a     = ai;
        b     = bi;
        dis   = di;
        clr   = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic ai, input logic bi, input logic di, input logic ci,
                       input logic em, input logic [1:0] en, input logic ef, input logic ea,
                       input logic [15:0] et);
        vec_t v;
        v.rst_n = r; v.a = ai; v.b = bi; v.dis = di; v.clr = ci;
        v.m = em; v.n = en; v.f = ef; v.act = ea; v.tot = et;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0; dis = 1'b0; clr = 1'b0;

        //  rst a b dis clr | m n f act tot   (FIRST_MATCH=1, window 1..2)
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,   0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0,   1, 1, 0, 0, 1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0,   0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0,   0, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 1);
        add(1, 0, 1, 0, 0,   1, 2, 0, 0, 3);
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 3);
        add(1, 0, 1, 0, 0,   1, 1, 0, 0, 4);
        add(1, 0, 1, 0, 0,   0, 0, 0, 0, 4);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 4);
        add(1, 0, 0, 1, 0,   0, 0, 0, 0, 4);
        add(1, 0, 1, 0, 0,   0, 0, 0, 0, 4);
        add(1, 1, 0, 1, 0,   0, 0, 0, 0, 4);
        add(1, 0, 1, 0, 0,   0, 0, 0, 0, 4);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 4);
        add(1, 0, 1, 1, 0,   0, 0, 0, 0, 4);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 4);
        add(1, 0, 1, 0, 1,   1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0,   0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 0);
        add(1, 0, 1, 0, 0,   1, 1, 0, 0, 1);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0,   0, 0, 0, 1, 0);
        add(1, 1, 1, 0, 0,   1, 1, 0, 1, 1);
        add(1, 0, 1, 0, 0,   1, 1, 0, 0, 2);
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 2);

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst_n, tbl[i].a, tbl[i].b, tbl[i].dis, tbl[i].clr);
            chk($sformatf("row%0d match", i),  32'(m1),   32'(tbl[i].m));
            chk($sformatf("row%0d num", i),    32'(n1),   32'(tbl[i].n));
            chk($sformatf("row%0d fail", i),   32'(f1),   32'(tbl[i].f));
            chk($sformatf("row%0d active", i), 32'(act1), 32'(tbl[i].act));
            chk($sformatf("row%0d total", i),  32'(t1),   32'(tbl[i].tot));
        end

        // Every match in the window reported, matched attempts never fail.
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0); chk("fm0 a active", 32'(act0), 1);
        drive(1, 0, 1, 0, 0); chk("fm0 b1 match", 32'(m0), 1);
                              chk("fm0 b1 active", 32'(act0), 1);
                              chk("fm0 b1 total", 32'(t0), 1);
        drive(1, 0, 1, 0, 0); chk("fm0 b2 match", 32'(m0), 1);
                              chk("fm0 b2 fail", 32'(f0), 0);
                              chk("fm0 b2 active", 32'(act0), 0);
                              chk("fm0 b2 total", 32'(t0), 2);
        drive(1, 0, 0, 0, 0); chk("fm0 idle match", 32'(m0), 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0); chk("fm0 once total", 32'(t0), 3);
        drive(1, 0, 0, 0, 0); chk("fm0 matched no fail", 32'(f0), 0);
                              chk("fm0 matched retire", 32'(act0), 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0); chk("fm0 overlap num", 32'(n0), 2);
                              chk("fm0 overlap active", 32'(act0), 1);
                              chk("fm0 overlap total", 32'(t0), 5);
        drive(1, 0, 1, 0, 0); chk("fm0 overlap tail num", 32'(n0), 1);
                              chk("fm0 overlap tail total", 32'(t0), 6);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0); chk("fm0 unmatched fail", 32'(f0), 1);

        // Narrow counter saturates, clear wins over a hit, reset drops attempts.
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0);
            drive(1, 0, 1, 0, 0);
            chk($sformatf("sat match%0d total", i), 32'(ts), (i + 1 > 3) ? 3 : i + 1);
        end
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 1); chk("sat clear match", 32'(ms), 1);
                              chk("sat clear total", 32'(ts), 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0); chk("sat recount", 32'(ts), 1);
        drive(1, 1, 0, 0, 0); chk("sat pending", 32'(acts), 1);
        drive(0, 0, 0, 0, 0); chk("sat rst total", 32'(ts), 0);
                              chk("sat rst active", 32'(acts), 0);
        drive(1, 0, 1, 0, 0); chk("sat rst no match", 32'(ms), 0);
                              chk("sat rst no fail", 32'(fs), 0);

        // Zero-delay window: a and b together match at age 0.
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 0, 0); chk("z same match", 32'(mz), 1);
                              chk("z same num", 32'(nz), 1);
                              chk("z same active", 32'(actz), 0);
        drive(1, 1, 0, 0, 0); chk("z a active", 32'(actz), 1);
        drive(1, 1, 1, 0, 0); chk("z two num", 32'(nz), 2);
                              chk("z two active", 32'(actz), 0);
                              chk("z two total", 32'(tz), 3);
        drive(1, 0, 1, 0, 0); chk("z b alone", 32'(mz), 0);
                              chk("z b alone fail", 32'(fz), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
